cu_pipe_stage: RTL

Registered decode/control stage for the SimpleRISC pipeline, sitting between instruction fetch and execute. It decodes each instruction into the ALU one-hot and control flags and extracts register specifiers and the immediate. The result is held in a single output register with valid/ready handshakes on both sides, plus flush, load-use interlock, illegal-opcode detection and a saturating stall counter.

---
 rtl/simple_risc_pkg.sv | 77 +++++++
 rtl/cu_pipe_stage_if.sv | 44 ++++
 rtl/cu_decode.sv | 83 ++++++++
 rtl/cu_pipe_stage.sv | 78 +++++++
 4 files changed

// File: rtl/simple_risc_pkg.sv
// SimpleRISC decode-stage constants, instruction field positions and control bundle.
// Combinational definitions only; no latency or backpressure of its own.
package simple_risc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int ALU_W   = 15;
  localparam int CNT_W   = 16;
  localparam logic [3:0] RA_IDX = 4'd15;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int I_BIT  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 14;
  localparam int IMM_HI = 17;
  localparam int IMM_LO = 0;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_NOP = 5'd13;
  localparam logic [4:0] OP_LD  = 5'd14;
  localparam logic [4:0] OP_ST  = 5'd15;
  localparam logic [4:0] OP_BEQ = 5'd16;
  localparam logic [4:0] OP_BGT = 5'd17;
  localparam logic [4:0] OP_B   = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET = 5'd20;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_MOD = 4;
  localparam int ALU_CMP = 5;
  localparam int ALU_AND = 6;
  localparam int ALU_OR  = 7;
  localparam int ALU_NOT = 8;
  localparam int ALU_MOV = 9;
  localparam int ALU_LSL = 10;
  localparam int ALU_LSR = 11;
  localparam int ALU_ASR = 12;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             isLd;
    logic             isSt;
    logic             isBeq;
    logic             isBgt;
    logic             isUBranch;
    logic             isCall;
    logic             isRet;
    logic             isWb;
    logic             isImmediate;
    logic             illegal;
    logic [3:0]       rd;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [17:0]      imm;
  } ctrl_t;

endpackage

// File: rtl/cu_pipe_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave is the stage's view, master is the surrounding pipeline's view.
interface cu_pipe_stage_if;
  import simple_risc_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ALU_W-1:0]   out_alu;
  logic               out_isLd;
  logic               out_isSt;
  logic               out_isBeq;
  logic               out_isBgt;
  logic               out_isUBranch;
  logic               out_isCall;
  logic               out_isRet;
  logic               out_isWb;
  logic               out_isImmediate;
  logic               out_illegal;
  logic [3:0]         out_rd;
  logic [3:0]         out_rs1;
  logic [3:0]         out_rs2;
  logic [17:0]        out_imm;
  logic [PC_W-1:0]    out_pc;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_alu, out_isLd, out_isSt, out_isBeq, out_isBgt,
           out_isUBranch, out_isCall, out_isRet, out_isWb, out_isImmediate,
           out_illegal, out_rd, out_rs1, out_rs2, out_imm, out_pc
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_alu, out_isLd, out_isSt, out_isBeq, out_isBgt,
           out_isUBranch, out_isCall, out_isRet, out_isWb, out_isImmediate,
           out_illegal, out_rd, out_rs1, out_rs2, out_imm, out_pc
  );

endinterface

// File: rtl/cu_decode.sv
// Combinational SimpleRISC instruction decoder: fields to ctrl_t plus source-use flags.
// Zero latency, no handshake.
module cu_decode
  import simple_risc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               useRs1,
  output logic               useRs2
);

  logic [4:0] opc;
  logic       iBit;
  logic       aluOp;

  always_comb begin
    opc    = instr[OPC_HI:OPC_LO];
    iBit   = instr[I_BIT];
    aluOp  = (opc <= OP_ASR);
    ctrl   = '0;
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    ctrl.rd  = instr[RD_HI:RD_LO];
    ctrl.rs1 = instr[RS1_HI:RS1_LO];
    ctrl.rs2 = instr[RS2_HI:RS2_LO];
    ctrl.imm = instr[IMM_HI:IMM_LO];

    if (aluOp) begin
      ctrl.isWb        = (opc != OP_CMP);
      ctrl.isImmediate = iBit;
      useRs1           = (opc != OP_NOT) && (opc != OP_MOV);
      useRs2           = !iBit;
    end

    case (opc)
      OP_ADD: ctrl.alu[ALU_ADD] = 1'b1;
      OP_SUB: ctrl.alu[ALU_SUB] = 1'b1;
      OP_MUL: ctrl.alu[ALU_MUL] = 1'b1;
      OP_DIV: ctrl.alu[ALU_DIV] = 1'b1;
      OP_MOD: ctrl.alu[ALU_MOD] = 1'b1;
      OP_CMP: ctrl.alu[ALU_CMP] = 1'b1;
      OP_AND: ctrl.alu[ALU_AND] = 1'b1;
      OP_OR:  ctrl.alu[ALU_OR]  = 1'b1;
      OP_NOT: ctrl.alu[ALU_NOT] = 1'b1;
      OP_MOV: ctrl.alu[ALU_MOV] = 1'b1;
      OP_LSL: ctrl.alu[ALU_LSL] = 1'b1;
      OP_LSR: ctrl.alu[ALU_LSR] = 1'b1;
      OP_ASR: ctrl.alu[ALU_ASR] = 1'b1;
      OP_NOP: ctrl.isImmediate = iBit;
      OP_LD: begin
        ctrl.alu[ALU_ADD] = 1'b1;
        ctrl.isLd         = 1'b1;
        ctrl.isWb         = 1'b1;
        ctrl.isImmediate  = iBit;
        useRs1            = 1'b1;
      end
      OP_ST: begin
        // store data travels on the rs2 port, so the rd field is read there
        ctrl.alu[ALU_ADD] = 1'b1;
        ctrl.isSt         = 1'b1;
        ctrl.isImmediate  = iBit;
        ctrl.rs2          = instr[RD_HI:RD_LO];
        useRs1            = 1'b1;
        useRs2            = 1'b1;
      end
      OP_BEQ: ctrl.isBeq     = 1'b1;
      OP_BGT: ctrl.isBgt     = 1'b1;
      OP_B:   ctrl.isUBranch = 1'b1;
      OP_CALL: begin
        ctrl.isCall = 1'b1;
        ctrl.isWb   = 1'b1;
        ctrl.rd     = RA_IDX;
      end
      OP_RET: begin
        ctrl.isRet = 1'b1;
        ctrl.rs1   = RA_IDX;
        useRs1     = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_pipe_stage.sv
// Registered decode stage: 1-cycle accept-to-valid, one bubble on load-use, flush wins.
// in_ready drops while the held entry is stalled downstream, on flush, or on a load-use hazard.
module cu_pipe_stage
  import simple_risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  cu_pipe_stage_if.slave    bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t           dec;
  ctrl_t           held;
  logic            heldVld;
  logic [PC_W-1:0] heldPc;
  logic            useRs1;
  logic            useRs2;
  logic            hazard;
  logic            accept;

  cu_decode uDecode (
    .instr  (bus.in_instr),
    .ctrl   (dec),
    .useRs1 (useRs1),
    .useRs2 (useRs2)
  );

  // compare against the decoded specifiers so ret (RA) and st (rd as data) are covered
  always_comb begin
    hazard = heldVld && held.isLd && bus.in_valid &&
             ((useRs1 && (dec.rs1 == held.rd)) || (useRs2 && (dec.rs2 == held.rd)));
    bus.in_ready = !bus.flush && !hazard && (!heldVld || bus.out_ready);
    accept = bus.in_valid && bus.in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heldVld <= 1'b0;
      held    <= '0;
      heldPc  <= '0;
    end else if (bus.flush) begin
      heldVld <= 1'b0;
    end else if (accept) begin
      heldVld <= 1'b1;
      held    <= dec;
      heldPc  <= bus.in_pc;
    end else if (bus.out_ready) begin
      heldVld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid       = heldVld;
  assign bus.out_alu         = held.alu;
  assign bus.out_isLd        = held.isLd;
  assign bus.out_isSt        = held.isSt;
  assign bus.out_isBeq       = held.isBeq;
  assign bus.out_isBgt       = held.isBgt;
  assign bus.out_isUBranch   = held.isUBranch;
  assign bus.out_isCall      = held.isCall;
  assign bus.out_isRet       = held.isRet;
  assign bus.out_isWb        = held.isWb;
  assign bus.out_isImmediate = held.isImmediate;
  assign bus.out_illegal     = held.illegal;
  assign bus.out_rd          = held.rd;
  assign bus.out_rs1         = held.rs1;
  assign bus.out_rs2         = held.rs2;
  assign bus.out_imm         = held.imm;
  assign bus.out_pc          = heldPc;

endmodule
